// File: rtl/dcpu_run_ctrl_if.sv
// dcpu_run_ctrl_if
// Bundles the run controller's CPU-side and front-panel signals.
//   master : the board / CPU side. It drives the switch, button, breakpoint and pc.
//            It receives cpu_ce, state and retire_cnt.
//   slave  : the dcpu_run_ctrl side, with the opposite directions.
// Signals:
//   run_sw     level switch, 1 = run, 0 = halt
//   step_btn   raw asynchronous step pushbutton
//   bp_en      breakpoint enable
//   bp_addr    breakpoint PC (32 bits)
//   pc         current CPU PC, valid from the cycle after cpu_ce
//   cpu_ce     one-cycle CPU advance enable
//   state      HALT=00, RUN=01, STEP=10, BREAK=11
//   retire_cnt count of cpu_ce pulses (32 bits, wrapping)
interface dcpu_run_ctrl_if;
    logic        run_sw;
    logic        step_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_ce;
    logic [1:0]  state;
    logic [31:0] retire_cnt;

    modport master (
        output run_sw, step_btn, bp_en, bp_addr, pc,
        input  cpu_ce, state, retire_cnt
    );

    modport slave (
        input  run_sw, step_btn, bp_en, bp_addr, pc,
        output cpu_ce, state, retire_cnt
    );
endinterface

// File: rtl/dcpu_run_ctrl.sv
// dcpu_run_ctrl
// This block is the run/halt/single-step sequencer for the board-level DCPU.
// It produces a one-cycle cpu_ce pulse:
//   - in RUN, once every 2^DIV_W cycles;
//   - once per debounced step-button press, from HALT or BREAK.
// The core halts when any of these occurs:
//   - run_sw goes low;
//   - a step completes;
//   - a PC breakpoint is hit.
// Ports:
//   clk_in  board clock, the only clock of this block
//   reset   synchronous active-high reset
//   bus     dcpu_run_ctrl_if.slave; it carries:
//             inputs  run_sw, step_btn, bp_en, bp_addr, pc
//             outputs cpu_ce, state, retire_cnt
// Parameters:
//   DIV_W   divider width; one RUN tick every 2^DIV_W cycles
//   DEB_W   debounce counter width; the button must be stable about 2^DEB_W cycles
// Build option:
//   DCPU_RUN_CTRL_BP_EN  When defined, the breakpoint comparator and the armed flag are built.
//                        When undefined, bp_en, bp_addr and pc are ignored and BREAK cannot be reached.
module dcpu_run_ctrl #(
    parameter int DIV_W = 15,
    parameter int DEB_W = 16
) (
    input  logic          clk_in,
    input  logic          reset,
    dcpu_run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] DIV_MAX = '1;
    localparam logic [DEB_W-1:0] DEB_MAX = '1;

    state_t           state_q, state_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic [31:0]      retire_q, retire_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync_prev_q, sync_prev_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_lvl_q, deb_lvl_d;
    logic             step_pulse_q, step_pulse_d;
    logic             from_break_q, from_break_d;
    logic             tick;
    logic             bp_hit;

`ifdef DCPU_RUN_CTRL_BP_EN
    // Entering RUN disarms the breakpoint. The first retired instruction re-arms it.
    // A resume sitting on the breakpoint PC therefore executes before it can re-hit.
    logic armed_q, armed_d;

    always_comb begin
        armed_d = armed_q;
        if (state_q == ST_HALT && bus.run_sw)
            armed_d = 1'b0;
        else if (state_q == ST_RUN && cpu_ce_q)
            armed_d = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (reset)
            armed_q <= 1'b0;
        else
            armed_q <= armed_d;
    end

    assign bp_hit = bus.bp_en && (bus.pc == bus.bp_addr) && armed_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bus.bp_en, bus.bp_addr, bus.pc};
    assign bp_hit    = 1'b0;
`endif

    assign tick = (state_q == ST_RUN) && (div_q == DIV_MAX);

    always_comb begin
        // Step button path: synchronize, debounce, then detect the rising edge.
        sync1_d     = bus.step_btn;
        sync2_d     = sync1_q;
        sync_prev_d = sync2_q;
        deb_cnt_d   = deb_cnt_q;
        deb_lvl_d   = deb_lvl_q;
        if (sync2_q != sync_prev_q)
            deb_cnt_d = '0;
        else if (deb_cnt_q != DEB_MAX)
            deb_cnt_d = deb_cnt_q + 1'b1;
        else
            deb_lvl_d = sync2_q;
        step_pulse_d = deb_lvl_d & ~deb_lvl_q;

        state_d      = state_q;
        cpu_ce_d     = 1'b0;
        div_d        = div_q;
        from_break_d = from_break_q;

        case (state_q)
            ST_HALT: begin
                if (bus.run_sw) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end else if (step_pulse_q) begin
                    state_d      = ST_STEP;
                    cpu_ce_d     = 1'b1;
                    from_break_d = 1'b0;
                end
            end
            ST_RUN: begin
                div_d = div_q + 1'b1;
                // A tick is suppressed when the run is ending this cycle.
                // No instruction may retire after a halt or a breakpoint.
                if (!bus.run_sw)
                    state_d = ST_HALT;
                else if (bp_hit)
                    state_d = ST_BREAK;
                else
                    cpu_ce_d = tick;
            end
            ST_STEP: begin
                // A step taken from BREAK with run_sw still high returns to BREAK.
                // The operator must toggle run_sw to resume.
                state_d = (from_break_q && bus.run_sw) ? ST_BREAK : ST_HALT;
            end
            ST_BREAK: begin
                if (!bus.run_sw)
                    state_d = ST_HALT;
                else if (step_pulse_q) begin
                    state_d      = ST_STEP;
                    cpu_ce_d     = 1'b1;
                    from_break_d = 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase

        retire_d = retire_q + {31'd0, cpu_ce_q};
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= ST_HALT;
            cpu_ce_q     <= 1'b0;
            retire_q     <= '0;
            div_q        <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync_prev_q  <= 1'b0;
            deb_cnt_q    <= '0;
            deb_lvl_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            from_break_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_ce_q     <= cpu_ce_d;
            retire_q     <= retire_d;
            div_q        <= div_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync_prev_q  <= sync_prev_d;
            deb_cnt_q    <= deb_cnt_d;
            deb_lvl_q    <= deb_lvl_d;
            step_pulse_q <= step_pulse_d;
            from_break_q <= from_break_d;
        end
    end

    assign bus.cpu_ce     = cpu_ce_q;
    assign bus.state      = state_q;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_dcpu_run_ctrl.sv
// tb_dcpu_run_ctrl
// Scoreboard bench for dcpu_run_ctrl with DIV_W=3 and DEB_W=2.
// Stimulus tasks predict every cpu_ce pulse from the run/step/breakpoint rules and queue it.
// Each prediction holds the expected cycle, retire count and state.
// A negedge monitor pops and compares one entry per observed pulse.
// The bench follows the DUT's breakpoint build option.
// The default build expects no BREAK and uninterrupted pulses.
module tb_dcpu_run_ctrl;
    localparam int DIV_W  = 3;
    localparam int DEB_W  = 2;
    localparam int PERIOD = 8;   // cycles between RUN pulses
`ifdef DCPU_RUN_CTRL_BP_EN
    localparam bit BP_BUILD = 1'b1;
`else
    localparam bit BP_BUILD = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    dcpu_run_ctrl_if bus();

    dcpu_run_ctrl #(.DIV_W(DIV_W), .DEB_W(DEB_W)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Stand-in CPU: pc advances by one instruction per retired cpu_ce.
    logic [31:0] pc_model = '0;
    logic        pc_clr   = 1'b1;
    always @(posedge clk_in) begin
        if (pc_clr)
            pc_model <= '0;
        else if (bus.cpu_ce === 1'b1)
            pc_model <= pc_model + 32'd4;
    end
    assign bus.pc = pc_model;

    typedef struct {
        int          cyc;     // -1: timing not predicted (button-driven)
        logic [31:0] retire;
        logic [1:0]  st;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0, step_seen = 0, brk_seen = 0;
    logic [31:0] m_retire = '0, m_pc = '0;
    int          m_steps = 0;
    bit          m_bp_en = 1'b0;

    // Monitor
    always @(negedge clk_in) begin
        exp_t e;
        if (bus.state === 2'b10) step_seen++;
        if (bus.state === 2'b11) brk_seen++;
        if (bus.cpu_ce === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ce: cpu_ce=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = sb.pop_front();
                if ((e.cyc >= 0 && e.cyc != cyc) || bus.retire_cnt !== e.retire || bus.state !== e.st) begin
                    errors++;
                    $display("FAIL ce_event: cycle %0d retire %0d state %b, required cycle %0d retire %0d state %b",
                             cyc, bus.retire_cnt, bus.state, e.cyc, e.retire, e.st);
                end else begin
                    $display("ce cycle %0d retire %0d state %b pc 0x%0h", cyc, bus.retire_cnt, bus.state, pc_model);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // A run entered at edge 'entry' with run_sw dropped during cycle 'stop'.
    // It retires one instruction every PERIOD cycles, up to and including cycle 'stop'.
    // The first retirement arms the breakpoint.
    // A match on the new pc halts the run one cycle later, provided run_sw is still high then.
    task automatic model_run(input int entry, input int stop, output int break_at);
        break_at = -1;
        for (int t = entry + PERIOD; t <= stop; t += PERIOD) begin
            sb.push_back('{t, m_retire, 2'b01});
            m_retire = m_retire + 32'd1;
            m_pc     = m_pc + 32'd4;
            if (BP_BUILD && m_bp_en && m_pc == bus.bp_addr && t + 1 < stop) begin
                break_at = t + 2;
                return;
            end
        end
    endtask

    task automatic model_step();
        sb.push_back('{-1, m_retire, 2'b10});
        m_retire = m_retire + 32'd1;
        m_pc     = m_pc + 32'd4;
        m_steps++;
    endtask

    // Hold run_sw high for 'hold' cycles.
    // Optionally press step at offset 'press_at'; the press counts only if the run is sitting in BREAK.
    // Optionally probe retire_cnt at offset 'probe_i'.
    task automatic run_seg(input int hold, input int press_at, input int probe_i, input logic [31:0] probe_val);
        int k, brk;
        k = cyc;
        bus.run_sw = 1'b1;
        model_run(k + 1, k + hold, brk);
        for (int i = 1; i <= hold; i++) begin
            next_cycle();
            if (i == probe_i) begin
                check("probe_retire", bus.retire_cnt, probe_val);
                check("probe_state", 32'(bus.state), 32'd1);
            end
            if (i == press_at) begin
                bus.step_btn = 1'b1;
                if (brk >= 0 && brk <= cyc) model_step();
            end
            if (press_at > 0 && i == press_at + 10) bus.step_btn = 1'b0;
        end
        check("seg_end_state", 32'(bus.state), (brk >= 0) ? 32'd3 : 32'd1);
        bus.run_sw = 1'b0;
        next_cycle();
        check("seg_halt_state", 32'(bus.state), 32'd0);
        check("seg_retire", bus.retire_cnt, m_retire);
        check("seg_pc", pc_model, m_pc);
    endtask

    task automatic press_halt(input int hi, input int lo, input bit expect_step);
        bus.step_btn = 1'b1;
        if (expect_step) model_step();
        repeat (hi) next_cycle();
        bus.step_btn = 1'b0;
        repeat (lo) next_cycle();
    endtask

    initial begin
        int k, hold, r, press;
        bus.run_sw   = 1'b0;
        bus.step_btn = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = '0;

        // Reset state
        repeat (3) next_cycle();
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_ce", 32'(bus.cpu_ce), 32'd0);
        check("reset_retire", bus.retire_cnt, 32'd0);
        reset  = 1'b0;
        pc_clr = 1'b0;
        next_cycle();

        // Free run for 40 cycles: pulses at 8, 16, 24 and 32; retire=4 at cycle 35
        run_seg(40, 0, 36, 32'd4);

        // Two clean step presses from HALT, then a 2-cycle glitch
        press_halt(10, 10, 1'b1);
        press_halt(10, 10, 1'b1);
        press_halt(2, 12, 1'b0);
        check("step_count_a", 32'(step_seen), 32'(m_steps));
        check("step_retire", bus.retire_cnt, m_retire);

        // Breakpoint at 0x0C from pc=0
        pc_clr = 1'b1;
        next_cycle();
        pc_clr = 1'b0;
        m_pc   = '0;
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h0000_000C;
        m_bp_en     = 1'b1;
        // This run breaks at 0x0C, then a step press comes from BREAK.
        // Without the breakpoint build, the press arrives in RUN and is dropped.
        run_seg(114, 70, 0, 32'd0);
        // Resume after the run_sw toggle; with pc past 0x0C the run must not re-break at once.
        run_seg(20, 0, 0, 32'd0);

        // run_sw falls in the same cycle that pc reaches bp_addr: HALT wins
        bus.bp_addr = m_pc + 32'd8;
        run_seg(18, 0, 0, 32'd0);

        // Reset asserted during a RUN cpu_ce cycle
        k = cyc;
        bus.run_sw = 1'b1;
        model_run(k + 1, k + 9, r);
        repeat (9) next_cycle();
        check("rst_ce_high", 32'(bus.cpu_ce), 32'd1);
        reset      = 1'b1;
        pc_clr     = 1'b1;
        bus.run_sw = 1'b0;
        next_cycle();
        check("rst_mid_state", 32'(bus.state), 32'd0);
        check("rst_mid_ce", 32'(bus.cpu_ce), 32'd0);
        check("rst_mid_retire", bus.retire_cnt, 32'd0);
        m_retire = '0;
        m_pc     = '0;
        reset    = 1'b0;
        pc_clr   = 1'b0;
        next_cycle();

        // Randomized runs with optional breakpoints, and random presses/glitches in HALT
        for (int n = 0; n < 8; n++) begin
            hold        = int'($urandom_range(5, 45));
            m_bp_en     = 1'($urandom_range(0, 1));
            bus.bp_en   = m_bp_en;
            bus.bp_addr = m_pc + 32'(4 * $urandom_range(1, 4));
            press       = (!m_bp_en && hold >= 20) ? 3 : 0;
            run_seg(hold, press, 0, 32'd0);
            if ($urandom_range(0, 1) == 1)
                press_halt(int'($urandom_range(10, 14)), 12, 1'b1);
            else
                press_halt(int'($urandom_range(1, 2)), 12, 1'b0);
        end

        repeat (4) next_cycle();
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("step_count", 32'(step_seen), 32'(m_steps));
        check("break_seen", 32'(brk_seen != 0), 32'(BP_BUILD));
        check("final_retire", bus.retire_cnt, m_retire);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
